seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Parametrised multi-cycle integer divider for the CPU datapath's mult/div unit.
//   Computes quotient and remainder with a radix-2 restoring algorithm, one quotient bit per clock.
//   Signed or unsigned operation is selected per operation, with a start/busy/done handshake.
//   Results go to HI (remainder) and LO (quotient) for the mfhi/mflo path, and div-by-zero is flagged.
// PARAMETERS
//   WIDTH      32  operand/result width in bits (>=4)
//   SIGNED_EN  1   1: is_signed honoured; 0: is_signed ignored, always unsigned
// PORTS
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      request; sampled only in IDLE
//   is_signed  in   1      1: two's-complement operands; 0: unsigned; sampled with start
//   dividend   in   WIDTH  numerator; sampled with start
//   divisor    in   WIDTH  denominator; sampled with start
//   busy       out  1      high from the edge after accepted start until done
//   done       out  1      one-cycle pulse: hi/lo/div0 valid and updated
//   hi         out  WIDTH  remainder
//   lo         out  WIDTH  quotient
//   div0       out  1      last request had divisor==0; held until next accepted start
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, div0=0, hi=0, lo=0; internal regs cleared.
//     Reset applies at any time; in-flight operation discarded, no done.
//   States:
//     IDLE -> CALC on start with divisor!=0: latch |dividend|, |divisor|, sign_q, sign_r; cnt=WIDTH-1.
//     IDLE -> IDLE on start with divisor==0: next edge div0=1, done=1; hi/lo unchanged; busy stays 0.
//     CALC (WIDTH cycles): rem={rem[W-2:0],quo[W-1]}; trial=rem-dvs.
//       If trial>=0: rem=trial, shift in 1; else shift in 0. cnt-- each cycle; CALC -> FIX at cnt==0.
//     FIX (1 cycle): lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem; done=1, busy=0; -> IDLE.
//   Latency: start sampled at edge E0; done high in the cycle after edge E(WIDTH+1).
//     That is WIDTH+1 clocks; back-to-back start is allowed in the cycle done is high.
//   Handshake: start while busy (CALC/FIX) is ignored; no queueing; inputs need only be valid at E0.
//   done is never high two cycles in a row; busy and done are never high together.
//   Sign rules (signed mode): magnitudes via two's-complement negate in WIDTH+1 bits, so MIN is safe.
//     sign_q = dividend[W-1]^divisor[W-1]; sign_r = dividend[W-1]; remainder takes the dividend's sign.
//   Overflow MIN/-1 (signed): lo=MIN (wraps), hi=0, div0=0; no trap generated here.
//   Unsigned mode: operands used as-is; no negation.
//   div0 clears on the edge that accepts the next start; hi/lo hold their last values until the next done.
//   Internal datapath: rem WIDTH+1 bits for trial subtraction; cnt width $clog2(WIDTH).
// STRUCTURE
//   Package div_pkg: state enum {IDLE,CALC,FIX}; localparam CNT_W=$clog2(WIDTH).
//     Also abs/negate helper function shared with the multiplier.
//   Sub-module div_step: combinational one-bit restoring iteration.
//     (rem_in, quo_in, dvs) -> (rem_out, quo_out); instanced once inside the CALC datapath.
//   Top: FSM, counter, operand/sign registers, output registers.
// TESTING
//   1 Unsigned 100/7 -> after WIDTH+1 clks done=1, lo=14, hi=2, div0=0; busy high exactly WIDTH cycles.
//   2 Signed -100/7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); signed 100/-7 -> lo=-14, hi=2.
//   3 Unsigned 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1; same operands with signed -> lo=0, hi=0xFFFFFFFF.
//   4 Any/0 -> next edge div0=1, done=1, busy=0, hi/lo keep prior values.
//     Next start 9/3 -> div0 clears, lo=3, hi=0.
//   5 Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
//   6 Start 100/7; reassert start at CALC cycle 5 with 50/5 (ignored) -> result 14/2.
//     Assert reset at CALC cycle 10 -> busy=0, hi=lo=0, no done.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential divider of the mult/div unit.
//   - div_state_t : controller states (IDLE, CALC, FIX)
//   - cnt_width() : iteration-counter width for a given operand width
//   - cond_neg()  : two's-complement magnitude helper shared with the multiplier
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Counter must hold WIDTH-1; guard against a degenerate width of 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Conditionally negate a 64-bit two's-complement value. Negating the
  // most-negative value yields the same bit pattern, which read as unsigned
  // is exactly its magnitude.
  function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
//   Request/response bundle between the datapath and the divider.
//   master : start, is_signed, dividend, divisor  -> ; <- busy, done, hi, lo, div0
//   slave  : mirror image, used by seq_divider
// ---------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, hi, lo, div0
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, hi, lo, div0
  );

endinterface

// File: rtl/seq_divider_step.sv
// ---------------------------------------------------------------------------
// div_step
//   One combinational radix-2 restoring iteration.
//   rem_in  : partial remainder (always < dvs between iterations)
//   quo_in  : shift register holding remaining dividend bits / quotient bits
//   dvs     : divisor magnitude
//   rem_out : updated partial remainder
//   quo_out : quo_in shifted left with the new quotient bit in the LSB
// ---------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             trial_ok;

  // The shifted remainder is WIDTH+1 bits wide. When it is >= dvs the true
  // difference is < dvs, so it fits in WIDTH bits and a WIDTH-bit subtract
  // (which wraps through the top bit) gives the exact result.
  always_comb begin
    shifted  = {rem_in, quo_in[WIDTH-1]};
    trial_ok = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvs);
    trial    = shifted[WIDTH-1:0] - dvs;
    rem_out  = trial_ok ? trial : shifted[WIDTH-1:0];
    quo_out  = {quo_in[WIDTH-2:0], trial_ok};
  end

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Multi-cycle signed/unsigned integer divider, one quotient bit per clock.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : seq_divider_if.slave
//           start/is_signed/dividend/divisor sampled in IDLE only
//           busy high during the WIDTH iteration cycles
//           done one-cycle pulse when hi (remainder) / lo (quotient) / div0 update
//           div0 set on a zero divisor, cleared by the next accepted start
// ---------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic          clock,
  input logic          reset,
  seq_divider_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state;
  div_state_t       state_next;

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;
  logic             done_r;
  logic             div0_r;

  logic             use_signed;
  logic             div_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  // Operand magnitudes. A WIDTH-bit negate of MIN gives MIN's own pattern,
  // which as an unsigned number is its magnitude, so MIN needs no special case.
  always_comb begin
    use_signed = SIGNED_EN & bus.is_signed;
    div_zero   = (bus.divisor == '0);
    dvd_mag    = (use_signed & bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    dvs_mag    = (use_signed & bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .dvs     (dvs_r),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A zero-divisor request never leaves IDLE; it is answered directly.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start && !div_zero) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and result registers. hi/lo change only in FIX, so a
  // divide-by-zero leaves the previous result visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (div_zero) begin
              div0_r <= 1'b1;
              done_r <= 1'b1;
            end else begin
              div0_r <= 1'b0;
              rem_r  <= '0;
              quo_r  <= dvd_mag;
              dvs_r  <= dvs_mag;
              sign_q <= use_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              sign_r <= use_signed & bus.dividend[WIDTH-1];
              cnt    <= CNT_W'(WIDTH - 1);
            end
          end
        end
        CALC: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          cnt   <= cnt - CNT_W'(1);
        end
        FIX: begin
          lo_r   <= sign_q ? -quo_r : quo_r;
          hi_r   <= sign_r ? -rem_r : rem_r;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == CALC);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.div0 = div0_r;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Directed and randomized checks of seq_divider (WIDTH=32) against an
//   arithmetic reference built on SV integer division.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH), .SIGNED_EN(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_hi     = '0;
  logic [31:0] exp_lo     = '0;

  // Reference: truncating division; remainder carries the dividend's sign.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      q  = 32'(ua / ub);
      r  = 32'(ua % ub);
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full request: drive, time it, check result and handshake.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input string tag);
    int          cyc;
    int          busy_cyc;
    logic [31:0] q, r;
    logic        zero;
    zero = (b == 32'd0);
    if (!zero) begin
      model(sgn, a, b, q, r);
      exp_lo = q;
      exp_hi = r;
    end
    @(negedge clock);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
    bus.is_signed = 1'($urandom_range(0, 1));
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    cyc      = 0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && cyc < 3 * WIDTH) begin
      if (bus.busy === 1'b1) busy_cyc++;
      @(posedge clock);
      #1;
      cyc++;
    end
    checkOutput({tag, ".latency"}, 64'(cyc), zero ? 64'd0 : 64'(WIDTH + 1));
    checkOutput({tag, ".busy_cycles"}, 64'(busy_cyc), zero ? 64'd0 : 64'(WIDTH));
    checkOutput({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, ".lo"}, 64'(bus.lo), 64'(exp_lo));
    checkOutput({tag, ".hi"}, 64'(bus.hi), 64'(exp_hi));
    checkOutput({tag, ".div0"}, 64'(bus.div0), 64'(zero));
    @(posedge clock);
    #1;
    checkOutput({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          cyc;
    int          done_seen;
    logic [31:0] a, b;
    logic        sgn;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset.busy", 64'(bus.busy), 64'd0);
    checkOutput("reset.done", 64'(bus.done), 64'd0);
    checkOutput("reset.hi",   64'(bus.hi),   64'd0);
    checkOutput("reset.lo",   64'(bus.lo),   64'd0);
    checkOutput("reset.div0", 64'(bus.div0), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(1'b0, 32'd100, 32'd7, "u100_7");
    applyStimulus(1'b1, -32'sd100, 32'd7, "s-100_7");
    applyStimulus(1'b1, 32'd100, -32'sd7, "s100_-7");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd2, "uFFFF_2");
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd2, "sFFFF_2");
    applyStimulus(1'b0, 32'd12345, 32'd0, "div0");
    applyStimulus(1'b0, 32'd9, 32'd3, "u9_3");
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "smin_-1");

    // A second start during CALC must be ignored.
    exp_lo = 32'd14;
    exp_hi = 32'd2;
    @(negedge clock);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    while (cyc < 4) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(posedge clock);
    #1;
    cyc++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && cyc < 3 * WIDTH) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    checkOutput("ignored_start.latency", 64'(cyc), 64'(WIDTH + 1));
    checkOutput("ignored_start.lo", 64'(bus.lo), 64'(exp_lo));
    checkOutput("ignored_start.hi", 64'(bus.hi), 64'(exp_hi));
    @(posedge clock);
    #1;
    checkOutput("ignored_start.no_requeue", 64'(bus.busy), 64'd0);

    // Reset in the middle of CALC discards the operation.
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("midreset.busy", 64'(bus.busy), 64'd0);
    checkOutput("midreset.done", 64'(bus.done), 64'd0);
    checkOutput("midreset.hi",   64'(bus.hi),   64'd0);
    checkOutput("midreset.lo",   64'(bus.lo),   64'd0);
    @(negedge clock);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    done_seen = 0;
    for (int i = 0; i < WIDTH + 5; i++) begin
      @(posedge clock);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    checkOutput("midreset.no_done", 64'(done_seen), 64'd0);

    // Randomized requests with biased corner cases.
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       a = 32'h8000_0000;
        default: ;
      endcase
      applyStimulus(sgn, a, b, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
